// File: rtl/tank_sprite_engine.sv
// Tank movement and sprite-overlay engine: per-tank position/direction state,
// tick-driven movement with wall bounce, and a 3-stage sprite compositing pipeline.
module tank_sprite_engine #(
  parameter int unsigned NUM_TANKS  = 2,
  parameter int unsigned SPRITE_W   = 32,
  parameter int unsigned SPRITE_H   = 32,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned TICK_CNT   = 50000,
  parameter int unsigned STEP       = 1,
  parameter int unsigned BOUNCE     = 10,
  parameter int unsigned INIT_X     = 60,
  parameter int unsigned INIT_Y     = 60,
  parameter int unsigned INIT_PITCH = 100,
  parameter logic [7:0]  BG_COLOR    = 8'hFF,
  parameter logic [7:0]  TRANSPARENT = 8'h00,
  localparam int unsigned AW = $clog2(SPRITE_W * SPRITE_H)
) (
  input  logic                      clk_25m,
  input  logic                      rst,
  input  logic [9:0]                pixel_x,
  input  logic [9:0]                pixel_y,
  input  logic [7:0]                map_pixel,
  input  logic [5*NUM_TANKS-1:0]    btns,
  output logic [NUM_TANKS*AW-1:0]   sprite_addr,
  output logic [NUM_TANKS-1:0]      sprite_sel,
  input  logic [8*NUM_TANKS-1:0]    sprite_data,
  output logic [7:0]                screen_data,
  output logic [10*NUM_TANKS-1:0]   tank_x,
  output logic [10*NUM_TANKS-1:0]   tank_y,
  output logic [2*NUM_TANKS-1:0]    tank_dir,
  output logic                      tick
);

  localparam int unsigned XW = $clog2(SPRITE_W);
  localparam int unsigned YW = $clog2(SPRITE_H);
  localparam int unsigned CW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;

  localparam logic [CW-1:0]        TICK_LAST = CW'(TICK_CNT - 1);
  localparam logic signed [11:0]   X_MAX     = 12'(SCREEN_W - SPRITE_W);
  localparam logic signed [11:0]   Y_MAX     = 12'(SCREEN_H - SPRITE_H);
  localparam logic signed [11:0]   STEP_S    = 12'(STEP);
  localparam logic signed [11:0]   BOUNCE_S  = 12'(BOUNCE);

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  // Architectural tank state
  logic [CW-1:0]        tick_cnt;
  logic [9:0]           x_q   [NUM_TANKS];
  logic [9:0]           y_q   [NUM_TANKS];
  dir_e                 dir_q [NUM_TANKS];
  logic [NUM_TANKS-1:0] hit_q;

  // Stage-0 combinational terms
  logic [9:0]           dx       [NUM_TANKS];
  logic [9:0]           dy       [NUM_TANKS];
  logic [AW-1:0]        addr_nxt [NUM_TANKS];
  logic [NUM_TANKS-1:0] in_box;
  logic [NUM_TANKS-1:0] hit_now;
  logic [NUM_TANKS-1:0] sel_nxt;

  // Button decode and movement
  logic [NUM_TANKS-1:0] btn_valid;
  dir_e                 btn_dir [NUM_TANKS];
  logic [NUM_TANKS-1:0] unused_fire;
  logic signed [11:0]   sx      [NUM_TANKS];
  logic signed [11:0]   sy      [NUM_TANKS];
  logic [9:0]           x_nxt   [NUM_TANKS];
  logic [9:0]           y_nxt   [NUM_TANKS];

  // Raster pipeline
  logic [AW-1:0]        addr_q [NUM_TANKS];
  logic [NUM_TANKS-1:0] sel_q;
  logic [NUM_TANKS-1:0] in_box_d1;
  logic [NUM_TANKS-1:0] in_box_d2;
  logic [7:0]           map_d1;
  logic [7:0]           map_d2;
  logic [7:0]           screen_nxt;

  function automatic logic [9:0] clamp(input logic signed [11:0] v,
                                       input logic signed [11:0] hi);
    logic [9:0] r;
    if (v < 12'sd0)   r = 10'd0;
    else if (v > hi)  r = hi[9:0];
    else              r = v[9:0];
    return r;
  endfunction

  // Sprite dimensions are powers of two, so H-1-dy and W-1-dx are bit inversions.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    for (int i = 0; i < NUM_TANKS; i++) begin
      dx[i]       = pixel_x - x_q[i];
      dy[i]       = pixel_y - y_q[i];
      in_box[i]   = (pixel_x >= x_q[i]) && (pixel_y >= y_q[i]) &&
                    (dx[i] < 10'(SPRITE_W)) && (dy[i] < 10'(SPRITE_H));
      hit_now[i]  = in_box[i] && (map_pixel != BG_COLOR);
      sel_nxt[i]  = (dir_q[i] == DIR_LEFT) || (dir_q[i] == DIR_RIGHT);
      addr_nxt[i] = {dy[i][YW-1:0], dx[i][XW-1:0]};
      case (dir_q[i])
        DIR_DOWN:  addr_nxt[i] = {~dy[i][YW-1:0], dx[i][XW-1:0]};
        DIR_RIGHT: addr_nxt[i] = {dy[i][YW-1:0], ~dx[i][XW-1:0]};
        default:   addr_nxt[i] = {dy[i][YW-1:0], dx[i][XW-1:0]};
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_TANKS; i++) begin
      btn_valid[i]   = $onehot(btns[5*i +: 4]);
      unused_fire[i] = btns[5*i+4];
      btn_dir[i]     = DIR_UP;
      if (btns[5*i+1])      btn_dir[i] = DIR_DOWN;
      else if (btns[5*i+2]) btn_dir[i] = DIR_LEFT;
      else if (btns[5*i+3]) btn_dir[i] = DIR_RIGHT;
    end
  end

  // A pending hit overrides the buttons and pushes the tank back against its heading.
  always_comb begin
    for (int i = 0; i < NUM_TANKS; i++) begin
      sx[i] = $signed({2'b00, x_q[i]});
      sy[i] = $signed({2'b00, y_q[i]});
      if (hit_q[i]) begin
        case (dir_q[i])
          DIR_UP:    sy[i] = sy[i] + BOUNCE_S;
          DIR_DOWN:  sy[i] = sy[i] - BOUNCE_S;
          DIR_LEFT:  sx[i] = sx[i] + BOUNCE_S;
          default:   sx[i] = sx[i] - BOUNCE_S;
        endcase
      end else if (btn_valid[i]) begin
        case (btn_dir[i])
          DIR_UP:    sy[i] = sy[i] - STEP_S;
          DIR_DOWN:  sy[i] = sy[i] + STEP_S;
          DIR_LEFT:  sx[i] = sx[i] - STEP_S;
          default:   sx[i] = sx[i] + STEP_S;
        endcase
      end
      x_nxt[i] = clamp(sx[i], X_MAX);
      y_nxt[i] = clamp(sy[i], Y_MAX);
    end
  end

  always_ff @(posedge clk_25m) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
      hit_q    <= '0;
      for (int i = 0; i < NUM_TANKS; i++) begin
        x_q[i]   <= 10'(INIT_X);
        y_q[i]   <= 10'(INIT_Y + i * INIT_PITCH);
        dir_q[i] <= DIR_UP;
      end
    end else begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        tick     <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt + CW'(1);
        tick     <= 1'b0;
      end
      // On a tick the old flag is consumed; a hit seen on that same edge survives.
      hit_q <= tick ? hit_now : (hit_q | hit_now);
      for (int i = 0; i < NUM_TANKS; i++) begin
        if (btn_valid[i]) dir_q[i] <= btn_dir[i];
        if (tick) begin
          x_q[i] <= x_nxt[i];
          y_q[i] <= y_nxt[i];
        end
      end
    end
  end

  // Lowest index wins, so scan from the top and let lower tanks overwrite.
  always_comb begin
    screen_nxt = map_d2;
    for (int i = NUM_TANKS - 1; i >= 0; i--) begin
      if (in_box_d2[i] && (sprite_data[8*i +: 8] != TRANSPARENT))
        screen_nxt = sprite_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      for (int i = 0; i < NUM_TANKS; i++) addr_q[i] <= '0;
      sel_q       <= '0;
      in_box_d1   <= '0;
      in_box_d2   <= '0;
      map_d1      <= '0;
      map_d2      <= '0;
      screen_data <= '0;
    end else begin
      for (int i = 0; i < NUM_TANKS; i++) begin
        if (in_box[i]) begin
          addr_q[i] <= addr_nxt[i];
          sel_q[i]  <= sel_nxt[i];
        end
      end
      in_box_d1   <= in_box;
      in_box_d2   <= in_box_d1;
      map_d1      <= map_pixel;
      map_d2      <= map_d1;
      screen_data <= screen_nxt;
    end
  end

  for (genvar g = 0; g < NUM_TANKS; g++) begin : g_out
    assign sprite_addr[g*AW +: AW] = addr_q[g];
    assign tank_x[10*g +: 10]      = x_q[g];
    assign tank_y[10*g +: 10]      = y_q[g];
    assign tank_dir[2*g +: 2]      = dir_q[g];
  end

  assign sprite_sel = sel_q;

endmodule

// File: tb/tb_tank_sprite_engine.sv
// Scoreboard bench for tank_sprite_engine: directed stimulus queues expected
// values keyed by cycle; a negedge monitor pops and compares them.
module tb_tank_sprite_engine;

  localparam int N  = 2;
  localparam int AW = 10;

  logic               clk_25m = 1'b0;
  logic               rst = 1'b1;
  logic [9:0]         pixel_x, pixel_y;
  logic [7:0]         map_pixel;
  logic [5*N-1:0]     btns;
  logic [N*AW-1:0]    sprite_addr;
  logic [N-1:0]       sprite_sel;
  logic [8*N-1:0]     sprite_data;
  logic [7:0]         screen_data;
  logic [10*N-1:0]    tank_x, tank_y;
  logic [2*N-1:0]     tank_dir;
  logic               tick;

  always #20 clk_25m = ~clk_25m;

  tank_sprite_engine #(.NUM_TANKS(N), .TICK_CNT(4)) dut (
    .clk_25m    (clk_25m),
    .rst        (rst),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .map_pixel  (map_pixel),
    .btns       (btns),
    .sprite_addr(sprite_addr),
    .sprite_sel (sprite_sel),
    .sprite_data(sprite_data),
    .screen_data(screen_data),
    .tank_x     (tank_x),
    .tank_y     (tank_y),
    .tank_dir   (tank_dir),
    .tick       (tick)
  );

  // Synchronous sprite ROM model: data = base ^ low address byte.
  logic [7:0] rom_base [N];
  always @(posedge clk_25m) begin
    for (int i = 0; i < N; i++)
      sprite_data[8*i +: 8] <= rom_base[i] ^ sprite_addr[AW*i +: 8];
  end

  typedef enum int {K_X, K_Y, K_DIR, K_ADDR, K_SEL, K_SCREEN, K_TICK} kind_e;
  typedef struct {
    int          due;
    kind_e       kind;
    int          idx;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   r0 = 0;

  always @(posedge clk_25m) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] actual(input kind_e k, input int idx);
    logic [15:0] v;
    case (k)
      K_X:      v = 16'(tank_x[10*idx +: 10]);
      K_Y:      v = 16'(tank_y[10*idx +: 10]);
      K_DIR:    v = 16'(tank_dir[2*idx +: 2]);
      K_ADDR:   v = 16'(sprite_addr[AW*idx +: AW]);
      K_SEL:    v = 16'(sprite_sel[idx]);
      K_SCREEN: v = 16'(screen_data);
      K_TICK:   v = 16'(tick);
      default:  v = 16'hDEAD;
    endcase
    return v;
  endfunction

  // Expectations are kept sorted by due cycle.
  task automatic push(input string name, input kind_e kind, input int idx,
                      input logic [15:0] exp, input int due);
    exp_t e;
    int   pos;
    e.due = due; e.kind = kind; e.idx = idx; e.exp = exp; e.name = name;
    pos = sb.size();
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].due > due) begin
        pos = k;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  always @(negedge clk_25m) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check(e.name, actual(e.kind, e.idx), e.exp);
    end
  end

  task automatic step();
    @(posedge clk_25m);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic set_btn(input int t, input logic [4:0] v);
    btns[5*t +: 5] = v;
  endtask

  task automatic set_pixel(input logic [9:0] x, input logic [9:0] y, input logic [7:0] m);
    pixel_x = x; pixel_y = y; map_pixel = m;
  endtask

  // Reset with a non-background map value so the screen pipeline reset is visible.
  task automatic do_reset();
    rst = 1'b1;
    btns = '0;
    set_pixel(10'd1023, 10'd1023, 8'h77);
    step();
    step();
    rst = 1'b0;
    map_pixel = 8'hFF;
    r0 = cyc;
    push("rst_x0",    K_X,      0, 16'd60,  r0);
    push("rst_y0",    K_Y,      0, 16'd60,  r0);
    push("rst_x1",    K_X,      1, 16'd60,  r0);
    push("rst_y1",    K_Y,      1, 16'd160, r0);
    push("rst_dir0",  K_DIR,    0, 16'd0,   r0);
    push("rst_dir1",  K_DIR,    1, 16'd0,   r0);
    push("rst_tick",  K_TICK,   0, 16'd0,   r0);
    push("rst_addr0", K_ADDR,   0, 16'd0,   r0);
    push("rst_sel0",  K_SEL,    0, 16'd0,   r0);
    push("rst_scr0",  K_SCREEN, 0, 16'd0,   r0);
    push("rst_scr1",  K_SCREEN, 0, 16'd0,   r0 + 1);
    push("rst_scr2",  K_SCREEN, 0, 16'd0,   r0 + 2);
  endtask

  initial begin
    rom_base[0] = 8'h80;
    rom_base[1] = 8'h40;
    btns = '0;
    set_pixel(10'd1023, 10'd1023, 8'h77);

    // Tank0 UP for three ticks; ticks visible at r0+4k, moves land at r0+4k+1.
    do_reset();
    set_btn(0, 5'b00001);
    push("up_y_pre",  K_Y,    0, 16'd60, r0 + 4);
    push("up_y_t1",   K_Y,    0, 16'd59, r0 + 5);
    push("up_y_t2",   K_Y,    0, 16'd58, r0 + 9);
    push("up_y_t3",   K_Y,    0, 16'd57, r0 + 13);
    push("tick_c3",   K_TICK, 0, 16'd0,  r0 + 3);
    push("tick_c4",   K_TICK, 0, 16'd1,  r0 + 4);
    push("tick_c5",   K_TICK, 0, 16'd0,  r0 + 5);
    push("tick_c8",   K_TICK, 0, 16'd1,  r0 + 8);
    push("tick_c11",  K_TICK, 0, 16'd0,  r0 + 11);
    push("tick_c12",  K_TICK, 0, 16'd1,  r0 + 12);
    wait_until(r0 + 14);

    // Tank0 facing right; raster across its box (base 0x80, screen lags 3 cycles).
    do_reset();
    set_btn(0, 5'b01000);
    step();
    set_btn(0, 5'b00000);
    set_pixel(10'd60, 10'd60, 8'hFF);
    push("r_dir",     K_DIR,    0, 16'd3,    r0 + 2);
    push("r_sel",     K_SEL,    0, 16'd1,    r0 + 2);
    push("r_addr_00", K_ADDR,   0, 16'd31,   r0 + 2);
    push("r_scr_00",  K_SCREEN, 0, 16'h9F,   r0 + 4);
    step();
    set_pixel(10'd91, 10'd60, 8'hFF);
    push("r_addr_w",  K_ADDR,   0, 16'd0,    r0 + 3);
    push("r_scr_w",   K_SCREEN, 0, 16'h80,   r0 + 5);
    step();
    set_pixel(10'd92, 10'd60, 8'h33);
    push("r_addr_hold", K_ADDR, 0, 16'd0,    r0 + 4);
    push("r_scr_outx",  K_SCREEN, 0, 16'h33, r0 + 6);
    step();
    set_pixel(10'd60, 10'd91, 8'hFF);
    push("r_addr_h",  K_ADDR,   0, 16'd1023, r0 + 5);
    push("r_scr_h",   K_SCREEN, 0, 16'h7F,   r0 + 7);
    step();
    set_pixel(10'd59, 10'd60, 8'h44);
    push("r_addr_hold2", K_ADDR, 0, 16'd1023, r0 + 6);
    push("r_scr_left",   K_SCREEN, 0, 16'h44, r0 + 8);
    push("r_x_hold",     K_X,   0, 16'd60,   r0 + 6);
    step();
    set_pixel(10'd1023, 10'd1023, 8'hFF);
    wait_until(r0 + 10);

    // Wall hit at (70,70) bounces tank0 down by 10; a hit on a tick edge waits a tick.
    do_reset();
    set_btn(1, 5'b01100);
    step();
    set_pixel(10'd70, 10'd70, 8'h00);
    push("h_scr",     K_SCREEN, 0, 16'hCA,  r0 + 4);
    push("h_y_pre",   K_Y,      0, 16'd60,  r0 + 4);
    push("h_y_bounce",K_Y,      0, 16'd70,  r0 + 5);
    push("h_x_keep",  K_X,      0, 16'd60,  r0 + 5);
    push("h_y_clear", K_Y,      0, 16'd70,  r0 + 9);
    push("h_y_late",  K_Y,      0, 16'd80,  r0 + 13);
    push("h_y_final", K_Y,      0, 16'd80,  r0 + 17);
    push("multi_y1",  K_Y,      1, 16'd160, r0 + 13);
    push("multi_x1",  K_X,      1, 16'd60,  r0 + 13);
    push("multi_dir1",K_DIR,    1, 16'd0,   r0 + 13);
    step();
    set_pixel(10'd1023, 10'd1023, 8'hFF);
    wait_until(r0 + 8);
    set_pixel(10'd61, 10'd71, 8'h00);
    step();
    set_pixel(10'd1023, 10'd1023, 8'hFF);
    wait_until(r0 + 18);

    // Clamp at the left wall (LEFT with FIRE) then at x=608 (RIGHT).
    do_reset();
    set_btn(0, 5'b10100);
    push("l_dir",     K_DIR, 0, 16'd2,   r0 + 2);
    push("l_x_1",     K_X,   0, 16'd1,   r0 + 237);
    push("l_x_0",     K_X,   0, 16'd0,   r0 + 241);
    push("l_x_clamp", K_X,   0, 16'd0,   r0 + 281);
    wait_until(r0 + 282);
    set_btn(0, 5'b01000);
    push("rr_x_607",  K_X,   0, 16'd607, r0 + 2709);
    push("rr_x_608",  K_X,   0, 16'd608, r0 + 2713);
    push("rr_dir",    K_DIR, 0, 16'd3,   r0 + 2713);
    push("rr_x_clamp",K_X,   0, 16'd608, r0 + 2761);
    wait_until(r0 + 2762);
    set_btn(0, 5'b00000);

    // Overlap: tank1 climbs to y=91, sharing row 91 with tank0 (tank0 wins unless transparent).
    do_reset();
    set_btn(1, 5'b00001);
    wait_until(r0 + 278);
    set_btn(1, 5'b00000);
    push("o_y1",      K_Y,      1, 16'd91,  r0 + 280);
    push("o_y1_hold", K_Y,      1, 16'd91,  r0 + 285);
    wait_until(r0 + 282);
    set_pixel(10'd61, 10'd91, 8'hFF);
    push("o_scr_t0",  K_SCREEN, 0, 16'h61,  r0 + 285);
    step();
    set_pixel(10'd1023, 10'd1023, 8'hFF);
    push("o_scr_bg",  K_SCREEN, 0, 16'hFF,  r0 + 286);
    step();
    rom_base[0] = 8'hE1;
    set_pixel(10'd61, 10'd91, 8'hFF);
    push("o_scr_t1",  K_SCREEN, 0, 16'h41,  r0 + 287);
    step();
    set_pixel(10'd1023, 10'd1023, 8'hFF);

    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    check("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
